// File: rtl/cache_arbiter.sv
// Round-robin arbiter that lets the instruction and data caches share one physical-memory port.
// Each granted request is latched and held on pmem until pmem_resp arrives.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state   | meaning
  // IDLE    | no transaction open, arbitrate on incoming requests
  // SERVE_I | icache transaction held on pmem until pmem_resp
  // SERVE_D | dcache transaction held on pmem until pmem_resp
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                req_i, req_d, pick_d;
  logic                serving;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_i    = i_read | i_write;
    req_d    = d_read | d_write;
    // On a tie the client that did not win last time gets the port.
    pick_d   = req_d & (~req_i | ~last_d_q);
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          wr_d     = d_write;
          addr_d   = d_address;
          wdata_d  = d_wdata;
        end else if (req_i) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          wr_d     = i_write;
          addr_d   = i_address;
          wdata_d  = i_wdata;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving & ~wr_q;
  assign pmem_write   = serving & wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = (state_q == SERVE_I) & pmem_resp;
  assign d_resp       = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [LW-1:0] DEADBEEF = 128'hDEAD0000_00000000_00000000_0000BEEF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_address, d_address, pmem_address;
  logic [LW-1:0] i_wdata, d_wdata, pmem_wdata, pmem_rdata, i_rdata, d_rdata;
  logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  int n_chk  = 0;
  int n_fail = 0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: owner of the open transaction (0 none, 1 icache, 2 dcache)
  // plus the command captured when it was granted.
  int            m_owner;
  logic          m_last_was_d;
  logic          m_is_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic          want_i, want_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner      = 0;
      m_last_was_d = 1'b0;
      m_is_write   = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
    end else if (m_owner == 0) begin
      want_i = i_read | i_write;
      want_d = d_read | d_write;
      if (want_d && (!want_i || !m_last_was_d)) begin
        m_owner = 2; m_last_was_d = 1'b1;
        m_is_write = d_write; m_addr = d_address; m_wdata = d_wdata;
      end else if (want_i) begin
        m_owner = 1; m_last_was_d = 1'b0;
        m_is_write = i_write; m_addr = i_address; m_wdata = i_wdata;
      end
    end else if (pmem_resp) begin
      m_owner = 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("pmem_read", LW'(pmem_read), LW'(m_owner != 0 && !m_is_write));
      chk("pmem_write", LW'(pmem_write), LW'(m_owner != 0 && m_is_write));
      chk("i_resp", LW'(i_resp), LW'(m_owner == 1 && pmem_resp));
      chk("d_resp", LW'(d_resp), LW'(m_owner == 2 && pmem_resp));
      if (m_owner != 0) begin
        chk("pmem_address", LW'(pmem_address), LW'(m_addr));
        chk("pmem_wdata", pmem_wdata, m_wdata);
      end
      if (m_owner == 1 && pmem_resp) chk("i_rdata", i_rdata, pmem_rdata);
      if (m_owner == 2 && pmem_resp) chk("d_rdata", d_rdata, pmem_rdata);
    end
  end

  initial begin
    reset_n = 1'b0;
    {i_read, i_write, d_read, d_write, pmem_resp} = '0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0; pmem_rdata = '0;
    tick(); tick();
    chk("rst pmem_read", LW'(pmem_read), '0);
    chk("rst pmem_write", LW'(pmem_write), '0);
    chk("rst resp", LW'({i_resp, d_resp}), '0);
    chk("rst pmem_address", LW'(pmem_address), '0);
    chk("rst pmem_wdata", pmem_wdata, '0);
    reset_n = 1'b1;
    tick();

    // icache read, memory answers in the third command cycle
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    i_read = 1'b0; i_address = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin pmem_resp = 1'b1; pmem_rdata = DEADBEEF; end
      #1;
      chk("t1 pmem_read", LW'(pmem_read), 1);
      chk("t1 pmem_address", LW'(pmem_address), LW'(16'h1230));
      chk("t1 i_resp", LW'(i_resp), LW'(k == 2));
      chk("t1 d_resp", LW'(d_resp), '0);
      if (k == 2) chk("t1 i_rdata", i_rdata, DEADBEEF);
      tick();
    end
    pmem_resp = 1'b0;
    chk("t1 idle after", LW'({pmem_read, pmem_write}), '0);

    // tie right after reset history (last grant I): D wins; address change mid-flight ignored
    i_read = 1'b1; i_address = 16'h2000;
    d_write = 1'b1; d_address = 16'h0040; d_wdata = 128'h1111;
    tick();
    chk("t2 d first write", LW'({pmem_read, pmem_write}), LW'(2'b01));
    chk("t2 d address", LW'(pmem_address), LW'(16'h0040));
    chk("t2 d wdata", pmem_wdata, 128'h1111);
    d_address = 16'h0080; d_wdata = 128'h2222;
    tick();
    chk("t2 latched address", LW'(pmem_address), LW'(16'h0040));
    pmem_resp = 1'b1; #1;
    chk("t2 d_resp", LW'({i_resp, d_resp}), LW'(2'b01));
    tick();
    d_write = 1'b0; pmem_resp = 1'b0;
    chk("t2 idle gap", LW'({pmem_read, pmem_write}), '0);
    tick();
    chk("t2 i second", LW'({pmem_read, pmem_address}), LW'({1'b1, 16'h2000}));
    pmem_resp = 1'b1;
    tick();
    i_read = 1'b0; pmem_resp = 1'b0;

    // d_write held high throughout while icache waits: grants go D, I, D
    d_write = 1'b1; d_address = 16'h0300;
    tick();
    i_read = 1'b1; i_address = 16'h0400;
    chk("t3 grant D", LW'(pmem_write), 1);
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; tick();
    chk("t3 grant I", LW'({pmem_read, pmem_address}), LW'({1'b1, 16'h0400}));
    pmem_resp = 1'b1; tick(); i_read = 1'b0; pmem_resp = 1'b0; tick();
    chk("t3 grant D again", LW'({pmem_write, pmem_address}), LW'({1'b1, 16'h0300}));
    pmem_resp = 1'b1; tick(); d_write = 1'b0; pmem_resp = 1'b0; tick();

    // stray pmem_resp while idle
    pmem_resp = 1'b1; #1;
    chk("t4 idle resp", LW'({i_resp, d_resp, pmem_read, pmem_write}), '0);
    tick(); pmem_resp = 1'b0; #1;
    chk("t4 still idle", LW'({pmem_read, pmem_write}), '0);

    // reset during SERVE_D, then first tie must go to D
    d_write = 1'b1; d_address = 16'h0500;
    tick();
    d_write = 1'b0;
    chk("t5 serve d", LW'(pmem_write), 1);
    pmem_resp = 1'b1; #2;
    reset_n = 1'b0; #1;
    chk("t5 async drop", LW'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    tick(); pmem_resp = 1'b0;
    reset_n = 1'b1;
    tick();
    i_read = 1'b1; d_read = 1'b1; i_address = 16'h0600; d_address = 16'h0700;
    tick();
    chk("t5 tie to D", LW'({pmem_read, pmem_address}), LW'({1'b1, 16'h0700}));
    i_read = 1'b0; d_read = 1'b0;
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; tick();

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      i_read    = ($urandom_range(0, 99) < 35);
      i_write   = ($urandom_range(0, 99) < 10);
      d_read    = ($urandom_range(0, 99) < 30);
      d_write   = ($urandom_range(0, 99) < 25);
      i_address = 16'($urandom);
      d_address = 16'($urandom);
      i_wdata   = {$urandom, $urandom, $urandom, $urandom};
      d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp = ($urandom_range(0, 99) < 35);
      tick();
    end
    {i_read, i_write, d_read, d_write, pmem_resp} = '0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client arbiter between the instruction cache (fetch stage) and the data cache (MEM stage, including LDI/STI double accesses) and the single physical-memory port. It accepts line-sized read/write requests from both caches, serialises them to physical memory one transaction at a time, and routes the response back to the granted cache. Ties are broken round-robin so neither pipeline stage starves.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- LINE_W, 128, cache line width in bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read  in  1  icache line-read request
- i_write  in  1  icache line-write request (unused by current icache, must be supported)
- i_address  in  ADDR_W  icache line address
- i_wdata  in  LINE_W  icache write line
- i_resp  out  1  icache transaction complete
- i_rdata  out  LINE_W  line returned to icache
- d_read  in  1  dcache line-read request
- d_write  in  1  dcache line-write (writeback) request
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache write line
- d_resp  out  1  dcache transaction complete
- d_rdata  out  LINE_W  line returned to dcache
- pmem_read  out  1  physical memory read command
- pmem_write  out  1  physical memory write command
- pmem_address  out  ADDR_W  physical memory address
- pmem_wdata  out  LINE_W  physical memory write line
- pmem_rdata  in  LINE_W  physical memory read line
- pmem_resp  in  1  physical memory transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D. One-bit last_grant register (I or D).
- IDLE: req_i = i_read|i_write, req_d = d_read|d_write.
  - only req_d -> SERVE_D; only req_i -> SERVE_I.
  - both -> grant the client opposite last_grant.
  - neither -> stay IDLE.
- On entering SERVE_x: latch client's address, wdata and op (write if x_write, else read; x_write has precedence if both asserted); set last_grant = x.
- SERVE_x: drive pmem_read/pmem_write, pmem_address, pmem_wdata from latched values only; stay until pmem_resp.
- pmem_resp in SERVE_x: x_resp = 1 that cycle (combinational), x_rdata = pmem_rdata; next state IDLE.
- Other client's resp is 0 always; its rdata is don't-care (drive pmem_rdata to both).
- Client dropping its request mid-transaction: command is held to pmem until pmem_resp (memory cannot abort); the resp is still pulsed to that client.
- pmem_resp in IDLE: ignored, no client resp.
- Client changing address/wdata mid-transaction: no effect (latched).
- Reset: state IDLE, last_grant = I (first tie goes to D), latched address/data 0; all outputs 0 (pmem_read, pmem_write, i_resp, d_resp = 0, pmem_address/pmem_wdata = 0).
- Reset asserted mid-transaction: immediately IDLE, pmem commands drop asynchronously; no resp issued.

## Timing
- Request first seen at edge N (IDLE) -> pmem command asserted from cycle N+1.
- pmem_resp in cycle M -> x_resp in cycle M, pmem command deasserted from M+1 (IDLE).
- Earliest next grant: request sampled at M+1 -> pmem command at M+2; one mandatory idle cycle between transactions.
- Caches must deassert request in cycle M+1; a request still high at M+1 is a new transaction.
- Arbitration overhead: 1 cycle per transaction plus memory latency; pmem_resp in the first SERVE cycle is legal (2-cycle total).
- Exactly one of pmem_read/pmem_write high in SERVE states; both low in IDLE.

## Test plan
- Reset then i_read, i_address=0x1230, pmem_resp after 3 cycles with rdata=0xDEAD…BEEF -> pmem_read high 3 cycles with address 0x1230, i_resp pulsed once with that data, d_resp stays 0.
- i_read and d_write asserted same cycle after reset -> D granted first (pmem_write, d_address/d_wdata), then I granted with one idle cycle between; repeat tie -> I then D (alternation).
- d_write continuously re-asserted while i_read pending -> grants alternate D, I, D; icache served within two transactions.
- Change d_address from 0x0040 to 0x0080 mid-transaction -> pmem_address remains 0x0040 until pmem_resp.
- pmem_resp pulsed in IDLE -> no i_resp/d_resp, state unchanged.
- reset_n low during SERVE_D -> pmem_write and all resp drop immediately; after release, IDLE, next tie grants D.
